pc_fetch_unit: RTL and testbench
================================

# pc_fetch_unit

Parametrised program-counter and fetch-request generator for the RISC-V core. It is the successor to the single-cycle PC register. It computes control-flow targets from the execute-stage instruction's own PC, so it works in a pipelined datapath. It drives a valid/ready request to instruction memory, supports stall, trap vectoring and misaligned-target detection, and holds a redirect while a fetch request is outstanding.

## Interface
Parameters:
- XLEN, 32: address/data width.
- RESET_VECTOR, 0: PC loaded on reset.
- TRAP_VECTOR, 32'h0000_0100: PC loaded on trap or misaligned target.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- stall  in  1  hold PC; suppresses new fetch requests.
- cf_valid  in  1  execute stage holds a valid instruction this cycle.
- opcode  in  7  execute-stage opcode.
- branch_taken  in  1  branch comparison result.
- imm  in  XLEN  sign-extended immediate.
- rs1  in  XLEN  rs1 operand, used by JALR.
- ex_pc  in  XLEN  PC of the execute-stage instruction.
- trap  in  1  synchronous exception request.
- imem_ready  in  1  instruction memory accepts the request.
- pc  out  XLEN  current fetch address.
- imem_valid  out  1  fetch request valid.
- link_addr  out  XLEN  ex_pc+4, combinational; the JAL/JALR rd value.
- redirect  out  1  one-cycle flush pulse for younger stages.
- misaligned  out  1  one-cycle pulse: the computed target was not 4-byte aligned.
- bad_target  out  XLEN  offending target, held until the next misaligned event.

## Operation
- Target computation, modulo 2^XLEN with carry discarded:
  - Branch (1100011): ex_pc+imm.
  - JAL (1101111): ex_pc+imm.
  - JALR (1100111): (rs1+imm) with bit 0 cleared across the full XLEN width.
- Redirect event (cf_valid high):
  - JAL and JALR always redirect.
  - A branch redirects only if branch_taken is high.
  - Other opcodes never redirect.
- Misaligned target: a redirect whose target[1:0] != 0.
  - Taken as a trap to TRAP_VECTOR instead of the target.
  - misaligned pulses; bad_target captures the target.
- Next-PC priority: reset > trap > misaligned redirect > redirect > stall > sequential (pc+4 on handshake).
- States:
  - BOOT: after reset. imem_valid=0. Always moves to FETCH next cycle.
  - FETCH: normal operation.
    - imem_valid = !stall, or a request is still open.
    - On a handshake (imem_valid && imem_ready): pc<=pc+4.
    - On a redirect or trap with no open request: pc<=new target, stay in FETCH.
    - On a redirect or trap while imem_valid && !imem_ready: store the target in pend_pc, go to WAIT; pc unchanged.
  - WAIT: imem_valid=1 with the old pc until imem_ready.
    - On the handshake: pc<=pend_pc, go to FETCH.
    - A later trap or redirect in WAIT overwrites pend_pc; the newest event wins.
- Valid/ready rule: once imem_valid is asserted, it and pc stay stable until imem_ready. stall never withdraws an open request.
- redirect pulses in the event cycle, whether or not the event is deferred to WAIT.

## Timing
- Reset values: pc=RESET_VECTOR, imem_valid=0, redirect=0, misaligned=0, bad_target=0, pend_pc=0, state=BOOT.
- Redirect latency: one cycle from the event edge to the new pc. If deferred, the new pc appears one cycle after the imem_ready handshake.
- trap and redirect in the same cycle: the trap wins; TRAP_VECTOR is loaded; redirect still pulses.
- stall with a redirect: the redirect is taken; stall only blocks sequential advance.
- Wrap-around: 32'hFFFF_FFFC+4 gives 0 with no flag.
- Reset asserted mid-WAIT: pend_pc is discarded and all outputs return to their reset values asynchronously.

## Structure
- Shared package rv_pkg holds:
  - opcode constants OP_BRANCH, OP_JAL, OP_JALR.
  - state enum pcf_state_t {BOOT, FETCH, WAIT}.
- A natural sub-module is next_pc_calc, combinational: target, redirect-event and misaligned logic. The top level keeps the state register, pc, pend_pc and the handshake.

## Test plan
- Reset then imem_ready=1 held → pc 0, 4, 8, 12 on successive cycles; imem_valid=0 for the one BOOT cycle.
- Taken branch: ex_pc=0x40, imm=-16 → pc=0x30 the next cycle; redirect pulses one cycle. The same stimulus with branch_taken=0 → no redirect.
- JALR with rs1=0x1001, imm=2 → pc=0x1002 not taken; misaligned=1, bad_target=0x1002, pc=TRAP_VECTOR. With rs1=0x1001, imm=3 → pc=0x1004.
- Redirect while imem_ready=0 for 3 cycles → pc and imem_valid stable over those cycles, then pc=target one cycle after the handshake.
- stall=1 with no open request → imem_valid=0 and pc frozen. Trap and JAL in the same cycle → pc=TRAP_VECTOR.
- Reset pulsed during WAIT → pc=RESET_VECTOR immediately; the pending target is never fetched.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared definitions for the RISC-V fetch front end: control-flow opcodes,
// fetch FSM states and a small alignment helper.
package rv_pkg;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2
  } pcf_state_t;

  function automatic logic word_misaligned(input logic [1:0] low_bits);
    return (low_bits != 2'b00);
  endfunction

endpackage

// File: rtl/pc_fetch_unit_next_pc_calc.sv
// Combinational control-flow resolution: target address, redirect event,
// misalignment and the resulting new fetch address.
module next_pc_calc
  import rv_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] TRAP_VECTOR = XLEN'(32'h0000_0100)
) (
  input  logic            cf_valid_i,
  input  logic [6:0]      opcode_i,
  input  logic            branch_taken_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] ex_pc_i,
  input  logic            trap_i,
  output logic [XLEN-1:0] target_o,
  output logic            redirect_o,
  output logic            misaligned_o,
  output logic            event_o,
  output logic [XLEN-1:0] new_pc_o
);

  logic [XLEN-1:0] pc_rel_s;
  logic [XLEN-1:0] reg_rel_s;

  assign pc_rel_s  = ex_pc_i + imm_i;
  assign reg_rel_s = rs1_i + imm_i;

  // Decode the execute-stage instruction into a target and a redirect decision.
  always_comb begin
    target_o   = pc_rel_s;
    redirect_o = 1'b0;
    case (opcode_i)
      OP_BRANCH: redirect_o = cf_valid_i && branch_taken_i;
      OP_JAL:    redirect_o = cf_valid_i;
      OP_JALR: begin
        target_o   = {reg_rel_s[XLEN-1:1], 1'b0};
        redirect_o = cf_valid_i;
      end
      default:   redirect_o = 1'b0;
    endcase
    misaligned_o = redirect_o && word_misaligned(target_o[1:0]);
    event_o      = trap_i || redirect_o;
    if (trap_i || misaligned_o) begin
      new_pc_o = TRAP_VECTOR;
    end else begin
      new_pc_o = target_o;
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction-fetch request generator; defers control-flow
// redirects while a fetch request is waiting for instruction memory.
module pc_fetch_unit
  import rv_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            cf_valid,
  input  logic [6:0]      opcode,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] ex_pc,
  input  logic            trap,
  input  logic            imem_ready,
  output logic [XLEN-1:0] pc,
  output logic            imem_valid,
  output logic [XLEN-1:0] link_addr,
  output logic            redirect,
  output logic            misaligned,
  output logic [XLEN-1:0] bad_target
);

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(3'd4);

  pcf_state_t      state_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pend_pc_q;
  logic [XLEN-1:0] bad_target_q;
  logic            req_open_q;

  logic [XLEN-1:0] target_s;
  logic [XLEN-1:0] new_pc_s;
  logic            redirect_s;
  logic            misaligned_s;
  logic            event_s;
  logic            valid_s;
  logic            handshake_s;
  logic            blocked_s;

  next_pc_calc #(
    .XLEN        (XLEN),
    .TRAP_VECTOR (TRAP_VECTOR)
  ) u_next_pc_calc (
    .cf_valid_i     (cf_valid),
    .opcode_i       (opcode),
    .branch_taken_i (branch_taken),
    .imm_i          (imm),
    .rs1_i          (rs1),
    .ex_pc_i        (ex_pc),
    .trap_i         (trap),
    .target_o       (target_s),
    .redirect_o     (redirect_s),
    .misaligned_o   (misaligned_s),
    .event_o        (event_s),
    .new_pc_o       (new_pc_s)
  );

  // An unaccepted request stays up regardless of stall.
  assign valid_s     = (state_q == WAIT) || ((state_q == FETCH) && (req_open_q || !stall));
  assign handshake_s = valid_s && imem_ready;
  assign blocked_s   = valid_s && !imem_ready;

  // Fetch FSM: pc, deferred target, open-request tracking and bad-target capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= BOOT;
      pc_q         <= RESET_VECTOR;
      pend_pc_q    <= '0;
      bad_target_q <= '0;
      req_open_q   <= 1'b0;
    end else begin
      req_open_q <= blocked_s;
      if (misaligned_s) begin
        bad_target_q <= target_s;
      end
      case (state_q)
        BOOT: begin
          state_q <= FETCH;
          if (event_s) begin
            pc_q <= new_pc_s;
          end
        end
        FETCH: begin
          if (event_s && blocked_s) begin
            pend_pc_q <= new_pc_s;
            state_q   <= WAIT;
          end else if (event_s) begin
            pc_q <= new_pc_s;
          end else if (handshake_s) begin
            pc_q <= pc_q + PC_STEP;
          end
        end
        WAIT: begin
          if (handshake_s) begin
            pc_q    <= event_s ? new_pc_s : pend_pc_q;
            state_q <= FETCH;
          end else if (event_s) begin
            pend_pc_q <= new_pc_s;
          end
        end
        default: state_q <= BOOT;
      endcase
    end
  end

  // Flush pulses belong to the event cycle; gating with reset keeps them low during reset.
  assign redirect   = reset && redirect_s;
  assign misaligned = reset && misaligned_s;
  assign pc         = pc_q;
  assign imem_valid = valid_s;
  assign link_addr  = ex_pc + PC_STEP;
  assign bad_target = bad_target_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: directed test-plan sequences plus random
// traffic, checked against a fetch-stream reference model.
module tb_pc_fetch_unit;
  import rv_pkg::*;

  localparam logic [31:0] RV = 32'h0000_0000;
  localparam logic [31:0] TV = 32'h0000_0100;
  localparam logic [6:0]  OP_ALU = 7'b0010011;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        cf_valid = 1'b0;
  logic [6:0]  opcode = 7'd0;
  logic        branch_taken = 1'b0;
  logic [31:0] imm = 32'd0;
  logic [31:0] rs1 = 32'd0;
  logic [31:0] ex_pc = 32'd0;
  logic        trap = 1'b0;
  logic        imem_ready = 1'b0;
  logic [31:0] pc;
  logic        imem_valid;
  logic [31:0] link_addr;
  logic        redirect;
  logic        misaligned;
  logic [31:0] bad_target;

  pc_fetch_unit #(.XLEN(32), .RESET_VECTOR(RV), .TRAP_VECTOR(TV)) dut (
    .clk(clk), .reset(reset), .stall(stall), .cf_valid(cf_valid), .opcode(opcode),
    .branch_taken(branch_taken), .imm(imm), .rs1(rs1), .ex_pc(ex_pc), .trap(trap),
    .imem_ready(imem_ready), .pc(pc), .imem_valid(imem_valid), .link_addr(link_addr),
    .redirect(redirect), .misaligned(misaligned), .bad_target(bad_target)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic        valid;
    logic [31:0] link;
    logic        redir;
    logic        mis;
    logic [31:0] bad;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  // Reference model: the address being fetched, a possibly deferred jump target,
  // whether last cycle's request went unanswered, and the last bad target.
  bit          m_boot = 1'b1;
  logic [31:0] m_pc = RV;
  bit          m_pend_v = 1'b0;
  logic [31:0] m_pend = 32'd0;
  bit          m_open = 1'b0;
  logic [31:0] m_bad = 32'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp_v);
    end
  endtask

  task automatic model_step();
    exp_t        e;
    bit          redir, mis, ev, valid;
    logic [31:0] tgt, dest;
    e.link = ex_pc + 32'd4;
    if (!reset) begin
      e.pc = RV; e.valid = 1'b0; e.redir = 1'b0; e.mis = 1'b0; e.bad = 32'd0;
      sb.push_back(e);
      m_boot = 1'b1; m_pc = RV; m_pend_v = 1'b0; m_open = 1'b0; m_bad = 32'd0;
    end else begin
      tgt = ex_pc + imm;
      redir = 1'b0;
      if (cf_valid) begin
        if (opcode == OP_JAL) redir = 1'b1;
        else if (opcode == OP_BRANCH) redir = branch_taken;
        else if (opcode == OP_JALR) begin
          tgt = rs1 + imm;
          tgt = tgt - (tgt % 32'd2);
          redir = 1'b1;
        end
      end
      mis   = redir && ((tgt % 32'd4) != 32'd0);
      ev    = trap || redir;
      dest  = (trap || mis) ? TV : tgt;
      valid = !m_boot && (m_pend_v || m_open || !stall);
      e.pc = m_pc; e.valid = valid; e.redir = redir; e.mis = mis; e.bad = m_bad;
      sb.push_back(e);
      if (mis) m_bad = tgt;
      if (m_boot) begin
        m_boot = 1'b0;
        if (ev) m_pc = dest;
      end else if (ev && valid && !imem_ready) begin
        m_pend_v = 1'b1;
        m_pend   = dest;
      end else if (ev) begin
        m_pc     = dest;
        m_pend_v = 1'b0;
      end else if (valid && imem_ready) begin
        m_pc     = m_pend_v ? m_pend : m_pc + 32'd4;
        m_pend_v = 1'b0;
      end
      m_open = valid && !imem_ready;
    end
  endtask

  task automatic cyc(input bit rst, input bit st, input bit rdy, input bit cv,
                     input logic [6:0] op, input bit bt, input logic [31:0] im,
                     input logic [31:0] r1, input logic [31:0] ep, input bit tr);
    @(posedge clk);
    #2;
    reset = rst; stall = st; imem_ready = rdy; cf_valid = cv; opcode = op;
    branch_taken = bt; imm = im; rs1 = r1; ex_pc = ep; trap = tr;
    model_step();
  endtask

  task automatic idle(input int n, input bit st, input bit rdy);
    for (int i = 0; i < n; i++) cyc(1'b1, st, rdy, 1'b0, OP_ALU, 1'b0, 32'd0, 32'd0, 32'h10, 1'b0);
  endtask

  // Monitor: compares every presented cycle against the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("pc", pc, e.pc);
        check("imem_valid", {31'd0, imem_valid}, {31'd0, e.valid});
        check("link_addr", link_addr, e.link);
        check("redirect", {31'd0, redirect}, {31'd0, e.redir});
        check("misaligned", {31'd0, misaligned}, {31'd0, e.mis});
        check("bad_target", bad_target, e.bad);
      end
    end
  end

  initial begin
    logic [31:0] im, r1, ep;
    logic [6:0]  op;
    int          sel;
    // Reset, then a sequential stream 0, 4, 8, 12 with one BOOT cycle.
    cyc(1'b0, 1'b0, 1'b1, 1'b0, OP_ALU, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, OP_ALU, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
    idle(6, 1'b0, 1'b1);
    // Taken branch 0x40-16, then the same branch not taken.
    cyc(1'b1, 1'b0, 1'b1, 1'b1, OP_BRANCH, 1'b1, 32'hFFFF_FFF0, 32'd0, 32'h40, 1'b0);
    idle(1, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b1, 1'b1, OP_BRANCH, 1'b0, 32'hFFFF_FFF0, 32'd0, 32'h40, 1'b0);
    idle(1, 1'b0, 1'b1);
    // JALR to a misaligned target, then to an aligned one.
    cyc(1'b1, 1'b0, 1'b1, 1'b1, OP_JALR, 1'b0, 32'd2, 32'h1001, 32'h80, 1'b0);
    idle(1, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b1, 1'b1, OP_JALR, 1'b0, 32'd3, 32'h1001, 32'h80, 1'b0);
    idle(2, 1'b0, 1'b1);
    // Redirect held off by three cycles of imem_ready low.
    cyc(1'b1, 1'b0, 1'b0, 1'b1, OP_JAL, 1'b0, 32'h80, 32'd0, 32'h200, 1'b0);
    idle(2, 1'b1, 1'b0);
    idle(3, 1'b0, 1'b1);
    // Stall with no open request, then trap and JAL together.
    idle(3, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, OP_JAL, 1'b0, 32'h40, 32'd0, 32'h500, 1'b1);
    idle(2, 1'b0, 1'b1);
    // Reset pulsed while a deferred target is pending.
    cyc(1'b1, 1'b0, 1'b0, 1'b1, OP_JAL, 1'b0, 32'h40, 32'd0, 32'h300, 1'b0);
    idle(1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, OP_ALU, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
    idle(4, 1'b0, 1'b1);
    // Wrap-around from the top of the address space.
    cyc(1'b1, 1'b0, 1'b1, 1'b1, OP_JAL, 1'b0, 32'h0000_00FC, 32'd0, 32'hFFFF_FF00, 1'b0);
    idle(3, 1'b0, 1'b1);
    // Random traffic.
    for (int n = 0; n < 1500; n++) begin
      sel = $urandom_range(0, 4);
      case (sel)
        0:       op = OP_BRANCH;
        1:       op = OP_JAL;
        2:       op = OP_JALR;
        3:       op = 7'b0110011;
        default: op = OP_ALU;
      endcase
      im = $urandom;
      r1 = $urandom;
      ep = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 3) != 0) im[1:0] = 2'b00;
      if ($urandom_range(0, 3) != 0) r1[1:0] = 2'b00;
      cyc(($urandom_range(0, 299) != 0), ($urandom_range(0, 4) == 0),
          ($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 3), op,
          $urandom_range(0, 1) == 1, im, r1, ep, ($urandom_range(0, 29) == 0));
    end
    idle(2, 1'b0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d entries left expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
